// File: rtl/pe_stream_controller.sv
// Layer-pass sequencer for one PE wrapper: configures the PE, feeds ifmap/filter/ipsum words
// from synchronous-read buffers into the PE FIFOs and drains opsum words into a result buffer.

// One feed channel. A read is issued only when words remain, the FIFO is not full and no
// read is in flight; the word is pushed (push_o=1) exactly one cycle later with the read data.
module pe_feed_channel #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active_i,
    input  logic          load_i,
    input  logic [AW-1:0] count_i,
    input  logic          fifo_full_i,
    input  logic [DW-1:0] rd_data_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          push_o,
    output logic [DW-1:0] data_o,
    output logic          drained_o
);
    logic [AW-1:0] rem_q, rem_d, addr_q, addr_d;
    logic          inflight_q;

    always_comb begin
        rd_en_o = active_i && (rem_q != '0) && !fifo_full_i && !inflight_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        if (load_i) begin
            rem_d  = count_i;
            addr_d = '0;
        end else if (inflight_q) begin
            rem_d  = rem_q - AW'(1);
            addr_d = addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            inflight_q <= rd_en_o;
        end
    end

    assign rd_addr_o = rd_en_o ? addr_q : '0;
    assign push_o    = inflight_q;
    assign data_o    = inflight_q ? rd_data_i : '0;
    // Looks at the next-cycle count so the FSM can leave STREAM right after the final push.
    assign drained_o = (rem_d == '0);
endmodule

module pe_stream_controller #(
    parameter int DATA_WIDTH_IFMAP  = 16,
    parameter int DATA_WIDTH_FILTER = 64,
    parameter int DATA_WIDTH_PSUM   = 64,
    parameter int W_WIDTH           = 8,
    parameter int S_WIDTH           = 5,
    parameter int F_WIDTH           = 6,
    parameter int U_WIDTH           = 3,
    parameter int n_WIDTH           = 3,
    parameter int p_WIDTH           = 5,
    parameter int q_WIDTH           = 3,
    parameter int IFMAP_ADDR_WIDTH  = 12,
    parameter int FILTER_ADDR_WIDTH = 8,
    parameter int PSUM_ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [W_WIDTH-1:0]           cfg_W,
    input  logic [S_WIDTH-1:0]           cfg_S,
    input  logic [F_WIDTH-1:0]           cfg_F,
    input  logic [U_WIDTH-1:0]           cfg_U,
    input  logic [n_WIDTH-1:0]           cfg_n,
    input  logic [p_WIDTH-1:0]           cfg_p,
    input  logic [q_WIDTH-1:0]           cfg_q,
    output logic                         busy,
    output logic                         done,
    output logic                         configure,
    output logic [W_WIDTH-1:0]           W,
    output logic [S_WIDTH-1:0]           S,
    output logic [F_WIDTH-1:0]           F,
    output logic [U_WIDTH-1:0]           U,
    output logic [n_WIDTH-1:0]           n,
    output logic [p_WIDTH-1:0]           p,
    output logic [q_WIDTH-1:0]           q,
    output logic                         ifmap_rd_en,
    output logic [IFMAP_ADDR_WIDTH-1:0]  ifmap_rd_addr,
    input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_rd_data,
    output logic                         filter_rd_en,
    output logic [FILTER_ADDR_WIDTH-1:0] filter_rd_addr,
    input  logic [DATA_WIDTH_FILTER-1:0] filter_rd_data,
    output logic                         ipsum_rd_en,
    output logic [PSUM_ADDR_WIDTH-1:0]   ipsum_rd_addr,
    input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_rd_data,
    output logic                         push_ifmap,
    output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
    input  logic                         ifmap_fifo_full,
    output logic                         push_filter,
    output logic [DATA_WIDTH_FILTER-1:0] filter,
    input  logic                         filter_fifo_full,
    output logic                         push_ipsum,
    output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
    input  logic                         ipsum_fifo_full,
    output logic                         pop_opsum,
    input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
    input  logic                         opsum_fifo_empty,
    output logic                         opsum_wr_en,
    output logic [PSUM_ADDR_WIDTH-1:0]   opsum_wr_addr,
    output logic [DATA_WIDTH_PSUM-1:0]   opsum_wr_data,
    output logic [1:0]                   state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, CONFIG = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic [W_WIDTH-1:0] w;
        logic [S_WIDTH-1:0] s;
        logic [F_WIDTH-1:0] f;
        logic [U_WIDTH-1:0] u;
        logic [n_WIDTH-1:0] n;
        logic [p_WIDTH-1:0] p;
        logic [q_WIDTH-1:0] q;
    } shape_t;

    localparam int IF_PW = n_WIDTH + W_WIDTH + q_WIDTH;
    localparam int FL_PW = p_WIDTH + q_WIDTH + S_WIDTH + 2;
    localparam int PS_PW = p_WIDTH + n_WIDTH + F_WIDTH + 2;

    state_t                       state_q, state_d;
    shape_t                       shape_q, shape_d;
    logic [PSUM_ADDR_WIDTH-1:0]   op_rem_q, op_rem_d, op_addr_q, op_addr_d;
    logic                         popped_q;
    logic                         streaming, loading;
    logic                         if_drained, flt_drained, ips_drained;
    logic [IF_PW-1:0]             if_prod;
    logic [FL_PW-1:0]             flt_prod;
    logic [PS_PW-1:0]             ps_prod;
    logic [IFMAP_ADDR_WIDTH-1:0]  n_if;
    logic [FILTER_ADDR_WIDTH-1:0] n_flt;
    logic [PSUM_ADDR_WIDTH-1:0]   n_ps;

    assign streaming = (state_q == STREAM);
    assign loading   = (state_q == CONFIG);

    // Full-width products; the +3 before the shift rounds the packed-word counts up.
    assign if_prod  = IF_PW'(shape_q.n) * IF_PW'(shape_q.w) * IF_PW'(shape_q.q);
    assign flt_prod = FL_PW'(shape_q.p) * FL_PW'(shape_q.q) * FL_PW'(shape_q.s) + FL_PW'(3);
    assign ps_prod  = PS_PW'(shape_q.p) * PS_PW'(shape_q.n) * PS_PW'(shape_q.f) + PS_PW'(3);
    assign n_if     = IFMAP_ADDR_WIDTH'(if_prod);
    assign n_flt    = FILTER_ADDR_WIDTH'(flt_prod >> 2);
    assign n_ps     = PSUM_ADDR_WIDTH'(ps_prod >> 2);

    pe_feed_channel #(.AW(IFMAP_ADDR_WIDTH), .DW(DATA_WIDTH_IFMAP)) u_ifmap_ch (
        .clk(clk), .reset(reset), .active_i(streaming), .load_i(loading), .count_i(n_if),
        .fifo_full_i(ifmap_fifo_full), .rd_data_i(ifmap_rd_data), .rd_en_o(ifmap_rd_en),
        .rd_addr_o(ifmap_rd_addr), .push_o(push_ifmap), .data_o(ifmap), .drained_o(if_drained)
    );

    pe_feed_channel #(.AW(FILTER_ADDR_WIDTH), .DW(DATA_WIDTH_FILTER)) u_filter_ch (
        .clk(clk), .reset(reset), .active_i(streaming), .load_i(loading), .count_i(n_flt),
        .fifo_full_i(filter_fifo_full), .rd_data_i(filter_rd_data), .rd_en_o(filter_rd_en),
        .rd_addr_o(filter_rd_addr), .push_o(push_filter), .data_o(filter), .drained_o(flt_drained)
    );

    pe_feed_channel #(.AW(PSUM_ADDR_WIDTH), .DW(DATA_WIDTH_PSUM)) u_ipsum_ch (
        .clk(clk), .reset(reset), .active_i(streaming), .load_i(loading), .count_i(n_ps),
        .fifo_full_i(ipsum_fifo_full), .rd_data_i(ipsum_rd_data), .rd_en_o(ipsum_rd_en),
        .rd_addr_o(ipsum_rd_addr), .push_o(push_ipsum), .data_o(ipsum), .drained_o(ips_drained)
    );

    // Drain: opsum is first-word-fall-through, so the write happens in the pop cycle.
    assign pop_opsum     = streaming && (op_rem_q != '0) && !opsum_fifo_empty && !popped_q;
    assign opsum_wr_en   = pop_opsum;
    assign opsum_wr_addr = pop_opsum ? op_addr_q : '0;
    assign opsum_wr_data = pop_opsum ? opsum : '0;

    always_comb begin
        state_d   = state_q;
        shape_d   = shape_q;
        op_rem_d  = op_rem_q;
        op_addr_d = op_addr_q;
        if (loading) begin
            op_rem_d  = n_ps;
            op_addr_d = '0;
        end else if (pop_opsum) begin
            op_rem_d  = op_rem_q - PSUM_ADDR_WIDTH'(1);
            op_addr_d = op_addr_q + PSUM_ADDR_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONFIG;
                    shape_d = '{w: cfg_W, s: cfg_S, f: cfg_F, u: cfg_U, n: cfg_n, p: cfg_p, q: cfg_q};
                end
            end
            CONFIG: state_d = STREAM;
            STREAM: begin
                if (if_drained && flt_drained && ips_drained && (op_rem_d == '0)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shape_q   <= '0;
            op_rem_q  <= '0;
            op_addr_q <= '0;
            popped_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shape_q   <= shape_d;
            op_rem_q  <= op_rem_d;
            op_addr_q <= op_addr_d;
            popped_q  <= pop_opsum;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign configure = loading;
    assign state_o   = state_q;
    assign W = configure ? shape_q.w : '0;
    assign S = configure ? shape_q.s : '0;
    assign F = configure ? shape_q.f : '0;
    assign U = configure ? shape_q.u : '0;
    assign n = configure ? shape_q.n : '0;
    assign p = configure ? shape_q.p : '0;
    assign q = configure ? shape_q.q : '0;
endmodule

// File: tb/tb_pe_stream_controller.sv
// Randomized bench for pe_stream_controller: buffer and PE FIFO models, expected-word queues
// filled from the layer shape, and a negedge monitor that checks every transfer.
module tb_pe_stream_controller;
  logic clk = 1'b0;
  logic reset, start;
  logic [7:0] cfg_W; logic [4:0] cfg_S; logic [5:0] cfg_F; logic [2:0] cfg_U;
  logic [2:0] cfg_n; logic [4:0] cfg_p; logic [2:0] cfg_q;
  logic busy, done, configure;
  logic [7:0] bus_W; logic [4:0] bus_S; logic [5:0] bus_F; logic [2:0] bus_U;
  logic [2:0] bus_n; logic [4:0] bus_p; logic [2:0] bus_q;
  logic ifmap_rd_en, filter_rd_en, ipsum_rd_en;
  logic [11:0] ifmap_rd_addr; logic [7:0] filter_rd_addr; logic [9:0] ipsum_rd_addr;
  logic [15:0] ifmap_rd_data; logic [63:0] filter_rd_data, ipsum_rd_data;
  logic push_ifmap, push_filter, push_ipsum, pop_opsum, opsum_wr_en;
  logic [15:0] ifmap; logic [63:0] filter, ipsum, opsum, opsum_wr_data;
  logic ifmap_fifo_full, filter_fifo_full, ipsum_fifo_full, opsum_fifo_empty;
  logic [9:0] opsum_wr_addr;
  logic [1:0] state_o;

  pe_stream_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_W(cfg_W), .cfg_S(cfg_S), .cfg_F(cfg_F), .cfg_U(cfg_U), .cfg_n(cfg_n), .cfg_p(cfg_p), .cfg_q(cfg_q),
    .busy(busy), .done(done), .configure(configure),
    .W(bus_W), .S(bus_S), .F(bus_F), .U(bus_U), .n(bus_n), .p(bus_p), .q(bus_q),
    .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr), .ifmap_rd_data(ifmap_rd_data),
    .filter_rd_en(filter_rd_en), .filter_rd_addr(filter_rd_addr), .filter_rd_data(filter_rd_data),
    .ipsum_rd_en(ipsum_rd_en), .ipsum_rd_addr(ipsum_rd_addr), .ipsum_rd_data(ipsum_rd_data),
    .push_ifmap(push_ifmap), .ifmap(ifmap), .ifmap_fifo_full(ifmap_fifo_full),
    .push_filter(push_filter), .filter(filter), .filter_fifo_full(filter_fifo_full),
    .push_ipsum(push_ipsum), .ipsum(ipsum), .ipsum_fifo_full(ipsum_fifo_full),
    .pop_opsum(pop_opsum), .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty),
    .opsum_wr_en(opsum_wr_en), .opsum_wr_addr(opsum_wr_addr), .opsum_wr_data(opsum_wr_data),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] ifmem [0:4095];
  logic [63:0] fmem [0:255];
  logic [63:0] pmem [0:1023];
  logic [15:0] exp_if[$];
  logic [63:0] exp_flt[$];
  logic [63:0] exp_ips[$];
  logic [73:0] exp_op[$];
  logic [63:0] ofifo[$];
  logic [32:0] exp_bus = '0;
  int op_gen = 0, op_budget = 0, stall_left = 0;
  bit stall_arm = 0;
  int if_rd_cnt, fl_rd_cnt, ps_rd_cnt, if_push_cnt, fl_push_cnt, ps_push_cnt, op_wr_cnt;
  int done_cnt, cfg_cnt, last_xfer;
  bit xfer_seen;
  logic prev_rd_if = 0, prev_rd_fl = 0, prev_rd_ps = 0, prev_pop = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buffer and PE FIFO models: inputs change 1 time unit after the rising edge.
  initial begin
    logic c_if_en, c_fl_en, c_ps_en, c_pop, c_push_if;
    logic [11:0] c_if_a; logic [7:0] c_fl_a; logic [9:0] c_ps_a;
    logic [63:0] ow; logic [9:0] oa;
    ifmap_fifo_full = 0; filter_fifo_full = 0; ipsum_fifo_full = 0; opsum_fifo_empty = 1;
    ifmap_rd_data = 0; filter_rd_data = 0; ipsum_rd_data = 0; opsum = 0;
    forever begin
      @(negedge clk);
      c_if_en = ifmap_rd_en; c_if_a = ifmap_rd_addr; c_fl_en = filter_rd_en; c_fl_a = filter_rd_addr;
      c_ps_en = ipsum_rd_en; c_ps_a = ipsum_rd_addr; c_pop = pop_opsum; c_push_if = push_ifmap;
      @(posedge clk); #1;
      ifmap_rd_data  = c_if_en ? ifmem[c_if_a] : 16'($urandom);
      filter_rd_data = c_fl_en ? fmem[c_fl_a] : {$urandom, $urandom};
      ipsum_rd_data  = c_ps_en ? pmem[c_ps_a] : {$urandom, $urandom};
      if (c_pop && ofifo.size() > 0) void'(ofifo.pop_front());
      if (op_gen < op_budget && $urandom_range(0, 2) != 0) begin
        ow = {$urandom, $urandom};
        oa = op_gen[9:0];
        ofifo.push_back(ow);
        exp_op.push_back({oa, ow});
        op_gen++;
      end
      opsum_fifo_empty = (ofifo.size() == 0);
      opsum = (ofifo.size() > 0) ? ofifo[0] : {$urandom, $urandom};
      if (stall_left > 0) stall_left--;
      if (stall_arm && c_push_if && if_push_cnt >= 10) begin
        stall_left = 20;
        stall_arm = 0;
      end
      ifmap_fifo_full  = (stall_left > 0) || ($urandom_range(0, 3) == 0);
      filter_fifo_full = ($urandom_range(0, 3) == 0);
      ipsum_fifo_full  = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [73:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_rd_if = 0; prev_rd_fl = 0; prev_rd_ps = 0; prev_pop = 0;
      end else begin
        check("cfg_bus", {bus_W, bus_S, bus_F, bus_U, bus_n, bus_p, bus_q}, configure ? exp_bus : 33'd0);
        if (configure) begin
          cfg_cnt++;
          check("cfg_no_xfer", {ifmap_rd_en, filter_rd_en, ipsum_rd_en, pop_opsum}, 4'd0);
        end
        if (done) begin
          done_cnt++;
          if (xfer_seen) check("done_latency", cyc - last_xfer, 1);
        end
        if (stall_left > 0) check("if_stall", {push_ifmap, ifmap_rd_en}, 2'd0);

        if (push_ifmap || prev_rd_if) check("if_rd_to_push", push_ifmap, prev_rd_if);
        if (ifmap_rd_en) begin check("if_rd_addr", ifmap_rd_addr, if_rd_cnt); if_rd_cnt++; end
        if (push_ifmap) begin
          if_push_cnt++; last_xfer = cyc; xfer_seen = 1;
          check("if_expected", exp_if.size() > 0, 1);
          if (exp_if.size() > 0) check("if_data", ifmap, exp_if.pop_front());
        end else check("if_idle_data", ifmap, 0);
        prev_rd_if = ifmap_rd_en;

        if (push_filter || prev_rd_fl) check("flt_rd_to_push", push_filter, prev_rd_fl);
        if (filter_rd_en) begin check("flt_rd_addr", filter_rd_addr, fl_rd_cnt); fl_rd_cnt++; end
        if (push_filter) begin
          fl_push_cnt++; last_xfer = cyc; xfer_seen = 1;
          check("flt_expected", exp_flt.size() > 0, 1);
          if (exp_flt.size() > 0) check("flt_data", filter, exp_flt.pop_front());
        end else check("flt_idle_data", filter, 0);
        prev_rd_fl = filter_rd_en;

        if (push_ipsum || prev_rd_ps) check("ips_rd_to_push", push_ipsum, prev_rd_ps);
        if (ipsum_rd_en) begin check("ips_rd_addr", ipsum_rd_addr, ps_rd_cnt); ps_rd_cnt++; end
        if (push_ipsum) begin
          ps_push_cnt++; last_xfer = cyc; xfer_seen = 1;
          check("ips_expected", exp_ips.size() > 0, 1);
          if (exp_ips.size() > 0) check("ips_data", ipsum, exp_ips.pop_front());
        end else check("ips_idle_data", ipsum, 0);
        prev_rd_ps = ipsum_rd_en;

        if (pop_opsum || opsum_wr_en) check("op_wr_with_pop", opsum_wr_en, pop_opsum);
        if (pop_opsum) begin
          op_wr_cnt++; last_xfer = cyc; xfer_seen = 1;
          check("op_pop_gap", prev_pop, 0);
          check("op_pop_nonempty", opsum_fifo_empty, 0);
          check("op_expected", exp_op.size() > 0, 1);
          if (exp_op.size() > 0) begin
            e = exp_op.pop_front();
            check("op_wr", {opsum_wr_addr, opsum_wr_data}, e);
          end
        end else check("op_idle_wr", {opsum_wr_addr, opsum_wr_data}, 0);
        prev_pop = pop_opsum;
      end
    end
  end

  task automatic clear_model();
    exp_if.delete(); exp_flt.delete(); exp_ips.delete(); exp_op.delete(); ofifo.delete();
    op_gen = 0; op_budget = 0; stall_left = 0; stall_arm = 0;
    if_rd_cnt = 0; fl_rd_cnt = 0; ps_rd_cnt = 0; if_push_cnt = 0; fl_push_cnt = 0; ps_push_cnt = 0;
    op_wr_cnt = 0; done_cnt = 0; cfg_cnt = 0; xfer_seen = 0; last_xfer = 0;
  endtask

  // Driver: one layer pass. Expected words come straight from the shape arithmetic.
  task automatic run_pass(input int w, input int s, input int f, input int u, input int nn,
                          input int pp, input int qq, input bit stall, input bit mid_start,
                          input int abort_at);
    int nif, nflt, nps;
    bit got_done;
    nif  = nn * w * qq;
    nflt = (pp * qq * s + 3) / 4;
    nps  = (pp * nn * f + 3) / 4;
    @(posedge clk); #2;
    clear_model();
    for (int i = 0; i < nif; i++) exp_if.push_back(ifmem[i]);
    for (int i = 0; i < nflt; i++) exp_flt.push_back(fmem[i]);
    for (int i = 0; i < nps; i++) exp_ips.push_back(pmem[i]);
    op_budget = nps;
    stall_arm = stall;
    exp_bus = {w[7:0], s[4:0], f[5:0], u[2:0], nn[2:0], pp[4:0], qq[2:0]};
    cfg_W = w[7:0]; cfg_S = s[4:0]; cfg_F = f[5:0]; cfg_U = u[2:0];
    cfg_n = nn[2:0]; cfg_p = pp[4:0]; cfg_q = qq[2:0];
    start = 1;
    @(posedge clk); #2;
    start = 0;
    {cfg_W, cfg_S, cfg_F, cfg_U, cfg_n, cfg_p, cfg_q} = 33'($urandom);
    @(negedge clk); #1;
    check("configure_after_start", {configure, busy}, 2'b11);
    got_done = 0;
    for (int c = 0; c < 20000 && !got_done; c++) begin
      @(posedge clk); #2;
      if (c == abort_at) begin
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
        clear_model();
        @(negedge clk); #1;
        check("abort_outputs", {busy, done, configure, ifmap_rd_en, filter_rd_en, ipsum_rd_en,
              push_ifmap, push_filter, push_ipsum, pop_opsum, opsum_wr_en}, 11'd0);
        return;
      end
      start = mid_start && (c == 40);
      if (start) {cfg_W, cfg_S, cfg_F, cfg_U, cfg_n, cfg_p, cfg_q} = 33'($urandom);
      @(negedge clk); #1;
      if (done) begin
        got_done = 1;
        check("busy_in_done", busy, 1);
      end
    end
    check("done_reached", got_done, 1);
    @(negedge clk); #1;
    check("idle_after_done", {busy, done}, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("configure_pulses", cfg_cnt, 1);
    check("ifmap_pushes", if_push_cnt, nif);
    check("filter_pushes", fl_push_cnt, nflt);
    check("ipsum_pushes", ps_push_cnt, nps);
    check("opsum_writes", op_wr_cnt, nps);
  endtask

  initial begin
    reset = 1; start = 0;
    {cfg_W, cfg_S, cfg_F, cfg_U, cfg_n, cfg_p, cfg_q} = '0;
    clear_model();
    for (int i = 0; i < 4096; i++) ifmem[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) fmem[i] = {$urandom, $urandom};
    for (int i = 0; i < 1024; i++) pmem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk); #1;
    check("reset_outputs", {busy, done, configure, ifmap_rd_en, filter_rd_en, ipsum_rd_en,
          push_ifmap, push_filter, push_ipsum, pop_opsum, opsum_wr_en, bus_W, bus_p}, 0);

    run_pass(227, 11, 55, 4, 1, 16, 1, 1, 1, -1);
    run_pass(20, 3, 10, 2, 0, 5, 2, 0, 0, -1);
    run_pass(8, 3, 5, 1, 1, 1, 1, 0, 0, -1);
    run_pass(100, 5, 20, 1, 2, 8, 1, 0, 0, 60);
    run_pass(30, 3, 7, 2, 1, 4, 2, 0, 0, -1);
    for (int k = 0; k < 5; k++)
      run_pass($urandom_range(1, 40), $urandom_range(1, 11), $urandom_range(1, 30), $urandom_range(1, 4),
               $urandom_range(0, 3), $urandom_range(1, 16), $urandom_range(1, 3), 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
